// File: rtl/fp32_pkg.sv
// Shared types and constants for the binary32 arithmetic unit.
package fp32_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_CMP = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_GT = 2'b01,
        CMP_LT = 2'b10,
        CMP_UN = 2'b11
    } cmp_e;

    localparam int          EXP_BIAS = 127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;
    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam logic [31:0] POS_INF  = 32'h7F800000;
    localparam logic [31:0] NEG_INF  = 32'hFF800000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp32_round_pack.sv
// Normalizes a 48-bit magnitude, rounds to nearest-even and packs a binary32
// word, flagging overflow to infinity and flush-to-zero underflow.
module fp32_round_pack
    import fp32_pkg::*;
(
    input  logic              sign_in,
    input  logic signed [9:0] exp_in,
    input  logic [47:0]       mant_in,
    output logic [31:0]       result,
    output logic              overflow,
    output logic              underflow
);

    // exp_in is the biased exponent of the value whose unit bit is mant_in[46]
    logic [5:0]        lzc;
    logic [47:0]       norm;
    logic signed [9:0] exp_norm;
    logic signed [9:0] exp_rnd;
    logic              guard;
    logic              round_bit;
    logic              sticky;
    logic              round_up;
    logic [24:0]       mant_rnd;

    always_comb begin
        lzc = 6'd0;
        for (int i = 0; i < 48; i++) begin
            if (mant_in[i]) begin
                lzc = 6'(47 - i);
            end
        end
    end

    always_comb begin
        norm      = mant_in << lzc;
        exp_norm  = exp_in + 10'sd1 - $signed({4'b0, lzc});
        guard     = norm[23];
        round_bit = norm[22];
        sticky    = |norm[21:0];
        round_up  = guard & (round_bit | sticky | norm[24]);
        mant_rnd  = {1'b0, norm[47:24]} + {24'b0, round_up};
        exp_rnd   = mant_rnd[24] ? exp_norm + 10'sd1 : exp_norm;

        result    = {sign_in, 31'b0};
        overflow  = 1'b0;
        underflow = 1'b0;
        if (mant_in != 48'b0) begin
            if (exp_rnd >= 10'sd255) begin
                result   = {sign_in, POS_INF[30:0]};
                overflow = 1'b1;
            end else if (exp_rnd <= 10'sd0) begin
                underflow = 1'b1;
            end else begin
                // a rounding carry leaves the fraction all-zero, so [22:0] is right either way
                result = {sign_in, exp_rnd[7:0], mant_rnd[22:0]};
            end
        end
    end

endmodule

// File: rtl/fp32_arith_unit.sv
// Registered binary32 add/sub/mul/compare unit with 1-cycle latency.
// Optional FPU_STICKY_FLAGS_EN adds accumulated {exception, overflow, underflow}.
module fp32_arith_unit
    import fp32_pkg::*;
#(
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        in_valid,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] result,
    output logic [1:0]  cmp,
    output logic        exception,
    output logic        overflow,
    output logic        underflow
`ifdef FPU_STICKY_FLAGS_EN
    ,
    output logic [2:0]  sticky_flags
`endif
);

    fp32_t       fa;
    fp32_t       fb;
    logic        a_zero;
    logic        b_zero;
    logic        a_inf_nan;
    logic        b_inf_nan;
    logic        a_nan;
    logic        b_nan;
    logic [23:0] ma;
    logic [23:0] mb;
    logic [30:0] mag_a;
    logic [30:0] mag_b;

    // Denormal operands are treated as signed zero everywhere
    always_comb begin
        fa        = a;
        fb        = b;
        a_zero    = (fa.exp == 8'h00);
        b_zero    = (fb.exp == 8'h00);
        a_inf_nan = (fa.exp == EXP_MAX);
        b_inf_nan = (fb.exp == EXP_MAX);
        a_nan     = a_inf_nan & (fa.frac != 23'b0);
        b_nan     = b_inf_nan & (fb.frac != 23'b0);
        ma        = a_zero ? 24'b0 : {1'b1, fa.frac};
        mb        = b_zero ? 24'b0 : {1'b1, fb.frac};
        mag_a     = a_zero ? 31'b0 : a[30:0];
        mag_b     = b_zero ? 31'b0 : b[30:0];
    end

    logic              sb_eff;
    logic              swap;
    logic              big_sign;
    logic [7:0]        big_exp;
    logic [7:0]        small_exp;
    logic [7:0]        diff;
    logic [47:0]       big_ext;
    logic [47:0]       small_ext;
    logic [47:0]       aligned;
    logic              lost;
    logic [47:0]       add_mant;
    logic              add_sign;
    logic signed [9:0] add_exp;

    // Shifted-out bits of the smaller operand are folded into bit 0 as a sticky bit
    always_comb begin
        sb_eff    = fb.sign ^ (op == OP_SUB);
        swap      = (mag_b > mag_a);
        big_sign  = swap ? sb_eff : fa.sign;
        big_exp   = swap ? fb.exp : fa.exp;
        small_exp = swap ? fa.exp : fb.exp;
        big_ext   = swap ? {1'b0, mb, 23'b0} : {1'b0, ma, 23'b0};
        small_ext = swap ? {1'b0, ma, 23'b0} : {1'b0, mb, 23'b0};
        diff      = big_exp - small_exp;
        if (diff >= 8'd48) begin
            aligned = 48'b0;
            lost    = |small_ext;
        end else begin
            aligned = small_ext >> diff;
            lost    = |(small_ext & ((48'd1 << diff) - 48'd1));
        end
        aligned  = aligned | {47'b0, lost};
        add_mant = (fa.sign == sb_eff) ? big_ext + aligned : big_ext - aligned;
        add_sign = (add_mant == 48'b0) ? (fa.sign & sb_eff) : big_sign;
        add_exp  = $signed({2'b0, big_exp});
    end

    logic [47:0]       mul_mant;
    logic              mul_sign;
    logic signed [9:0] mul_exp;

    always_comb begin
        mul_mant = {24'b0, ma} * {24'b0, mb};
        mul_sign = fa.sign ^ fb.sign;
        mul_exp  = $signed({2'b0, fa.exp}) + $signed({2'b0, fb.exp}) - 10'(EXP_BIAS);
    end

    logic              rp_sign;
    logic signed [9:0] rp_exp;
    logic [47:0]       rp_mant;
    logic [31:0]       rp_result;
    logic              rp_overflow;
    logic              rp_underflow;

    always_comb begin
        rp_sign = (op == OP_MUL) ? mul_sign : add_sign;
        rp_exp  = (op == OP_MUL) ? mul_exp  : add_exp;
        rp_mant = (op == OP_MUL) ? mul_mant : add_mant;
    end

    fp32_round_pack u_round_pack (
        .sign_in   (rp_sign),
        .exp_in    (rp_exp),
        .mant_in   (rp_mant),
        .result    (rp_result),
        .overflow  (rp_overflow),
        .underflow (rp_underflow)
    );

    cmp_e cmp_val;

    // Signed zeros compare equal; infinities order like any other magnitude
    always_comb begin
        if (a_nan | b_nan) begin
            cmp_val = CMP_UN;
        end else if ((mag_a == 31'b0) && (mag_b == 31'b0)) begin
            cmp_val = CMP_EQ;
        end else if (fa.sign != fb.sign) begin
            cmp_val = fa.sign ? CMP_LT : CMP_GT;
        end else if (mag_a == mag_b) begin
            cmp_val = CMP_EQ;
        end else if ((mag_a > mag_b) ^ fa.sign) begin
            cmp_val = CMP_GT;
        end else begin
            cmp_val = CMP_LT;
        end
    end

    logic        out_valid_d, out_valid_q;
    logic [31:0] result_d, result_q;
    logic [1:0]  cmp_d, cmp_q;
    logic        exception_d, exception_q;
    logic        overflow_d, overflow_q;
    logic        underflow_d, underflow_q;

    always_comb begin
        out_valid_d = in_valid;
        result_d    = result_q;
        cmp_d       = cmp_q;
        exception_d = exception_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (in_valid) begin
            exception_d = a_inf_nan | b_inf_nan;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            cmp_d       = CMP_EQ;
            if (op == OP_CMP) begin
                result_d = 32'b0;
                cmp_d    = cmp_val;
            end else if (a_inf_nan | b_inf_nan) begin
                result_d = CANON_NAN;
            end else begin
                result_d    = rp_result;
                overflow_d  = rp_overflow;
                underflow_d = rp_underflow;
            end
        end
    end

`ifdef FPU_STICKY_FLAGS_EN
    logic [2:0] sticky_flags_d, sticky_flags_q;

    always_comb begin
        sticky_flags_d = sticky_flags_q;
        if (in_valid) begin
            sticky_flags_d = sticky_flags_q | {exception_d, overflow_d, underflow_d};
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_q    <= 1'b0;
            result_q       <= 32'b0;
            cmp_q          <= 2'b0;
            exception_q    <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
`ifdef FPU_STICKY_FLAGS_EN
            sticky_flags_q <= 3'b0;
`endif
        end else begin
            out_valid_q    <= out_valid_d;
            result_q       <= result_d;
            cmp_q          <= cmp_d;
            exception_q    <= exception_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
`ifdef FPU_STICKY_FLAGS_EN
            sticky_flags_q <= sticky_flags_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cmp       = cmp_q;
    assign exception = exception_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`ifdef FPU_STICKY_FLAGS_EN
    assign sticky_flags = sticky_flags_q;
`endif

endmodule

// File: tb/tb_fp32_arith_unit.sv
// Directed self-checking bench for fp32_arith_unit with hand-computed vectors.
module tb_fp32_arith_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        in_valid;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] result;
    logic [1:0]  cmp;
    logic        exception;
    logic        overflow;
    logic        underflow;
`ifdef FPU_STICKY_FLAGS_EN
    logic [2:0]  sticky_flags;
`endif

    int checks   = 0;
    int failures = 0;

    fp32_arith_unit dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .cmp       (cmp),
        .exception (exception),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef FPU_STICKY_FLAGS_EN
        ,
        .sticky_flags (sticky_flags)
`endif
    );

    always #5 CLK = ~CLK;

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge
    task automatic applyStimulus(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i);
        @(negedge CLK);
        in_valid = 1'b1;
        op       = op_i;
        a        = a_i;
        b        = b_i;
        @(posedge CLK);
        #1;
    endtask

    task automatic idleCycle();
        @(negedge CLK);
        in_valid = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkFlags(input string tag, input logic exc_e, input logic ovf_e, input logic unf_e);
        checkOutput({tag, "_exception"}, {31'b0, exception}, {31'b0, exc_e});
        checkOutput({tag, "_overflow"},  {31'b0, overflow},  {31'b0, ovf_e});
        checkOutput({tag, "_underflow"}, {31'b0, underflow}, {31'b0, unf_e});
    endtask

    initial begin
        RESET    = 1'b1;
        in_valid = 1'b0;
        op       = 2'b00;
        a        = 32'h0;
        b        = 32'h0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        $display("[TB] reset released");
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_result", result, 32'h0);
        checkOutput("rst_cmp", {30'b0, cmp}, 32'd0);
        checkFlags("rst", 1'b0, 1'b0, 1'b0);

        applyStimulus(2'b00, 32'h430C0000, 32'h40A00000);
        checkOutput("add_145_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("add_145", result, 32'h43110000);
        checkFlags("add_145", 1'b0, 1'b0, 1'b0);

        applyStimulus(2'b01, 32'h41F00000, 32'h430C0000);
        checkOutput("sub_m110", result, 32'hC2DC0000);

        applyStimulus(2'b10, 32'h40A00000, 32'h41F00000);
        checkOutput("mul_150", result, 32'h43160000);

        applyStimulus(2'b10, 32'h7F000000, 32'h40000000);
        checkOutput("mul_ovf", result, 32'h7F800000);
        checkFlags("mul_ovf", 1'b0, 1'b1, 1'b0);

        applyStimulus(2'b11, 32'h41F00000, 32'h41F00000);
        checkOutput("cmp_eq", {30'b0, cmp}, 32'd0);
        checkOutput("cmp_eq_result", result, 32'h0);
        checkFlags("cmp_eq", 1'b0, 1'b0, 1'b0);

        applyStimulus(2'b11, 32'h41F00000, 32'h430C0000);
        checkOutput("cmp_lt", {30'b0, cmp}, 32'd2);

        applyStimulus(2'b11, 32'h80000000, 32'h00000000);
        checkOutput("cmp_zeros", {30'b0, cmp}, 32'd0);

        applyStimulus(2'b11, 32'h7FC00000, 32'h3F800000);
        checkOutput("cmp_nan", {30'b0, cmp}, 32'd3);
        checkOutput("cmp_nan_exc", {31'b0, exception}, 32'd1);

        applyStimulus(2'b11, 32'hC0000000, 32'hBF800000);
        checkOutput("cmp_neg_lt", {30'b0, cmp}, 32'd2);

        applyStimulus(2'b11, 32'h3F800000, 32'hBF800000);
        checkOutput("cmp_gt", {30'b0, cmp}, 32'd1);

        applyStimulus(2'b11, 32'h7F800000, 32'h3F800000);
        checkOutput("cmp_inf_gt", {30'b0, cmp}, 32'd1);
        checkOutput("cmp_inf_exc", {31'b0, exception}, 32'd1);

        applyStimulus(2'b01, 32'h3D23D70A, 32'h3D23D70A);
        checkOutput("sub_zero", result, 32'h00000000);
        checkFlags("sub_zero", 1'b0, 1'b0, 1'b0);

        applyStimulus(2'b00, 32'h7F800000, 32'h3F800000);
        checkOutput("add_inf", result, 32'h7FC00000);
        checkFlags("add_inf", 1'b1, 1'b0, 1'b0);

        applyStimulus(2'b00, 32'h3F800000, 32'h33800000);
        checkOutput("add_tie_even", result, 32'h3F800000);

        applyStimulus(2'b00, 32'h3F800000, 32'h33C00000);
        checkOutput("add_round_up", result, 32'h3F800001);

        applyStimulus(2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF);
        checkOutput("add_ovf", result, 32'h7F800000);
        checkFlags("add_ovf", 1'b0, 1'b1, 1'b0);

        applyStimulus(2'b00, 32'h80000000, 32'h80000000);
        checkOutput("add_negzero", result, 32'h80000000);

        applyStimulus(2'b00, 32'h00000001, 32'h3F800000);
        checkOutput("add_denorm", result, 32'h3F800000);

        applyStimulus(2'b10, 32'h00800000, 32'h3F000000);
        checkOutput("mul_unf", result, 32'h00000000);
        checkFlags("mul_unf", 1'b0, 1'b0, 1'b1);

        applyStimulus(2'b10, 32'h80800000, 32'h3F000000);
        checkOutput("mul_unf_neg", result, 32'h80000000);
        checkOutput("mul_unf_neg_flag", {31'b0, underflow}, 32'd1);

        applyStimulus(2'b10, 32'h80000000, 32'h40000000);
        checkOutput("mul_negzero", result, 32'h80000000);
        checkFlags("mul_negzero", 1'b0, 1'b0, 1'b0);

        $display("[TB] back-to-back, mid-stream reset and idle");
        applyStimulus(2'b00, 32'h430C0000, 32'h40A00000);
        checkOutput("b2b_add", result, 32'h43110000);

        @(negedge CLK);
        RESET    = 1'b1;
        in_valid = 1'b1;
        op       = 2'b10;
        a        = 32'h7F000000;
        b        = 32'h40000000;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        checkOutput("midrst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midrst_result", result, 32'h0);
        checkFlags("midrst", 1'b0, 1'b0, 1'b0);

        applyStimulus(2'b10, 32'h40A00000, 32'h41F00000);
        checkOutput("post_rst_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("post_rst_mul", result, 32'h43160000);

        applyStimulus(2'b01, 32'h41F00000, 32'h430C0000);
        checkOutput("b2b_sub_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("b2b_sub", result, 32'hC2DC0000);

        idleCycle();
        checkOutput("idle_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("idle_hold", result, 32'hC2DC0000);

        idleCycle();
        checkOutput("idle2_hold", result, 32'hC2DC0000);

        applyStimulus(2'b10, 32'h7F000000, 32'h40000000);
        checkOutput("resume_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("resume_ovf", {31'b0, overflow}, 32'd1);

        idleCycle();
        checkOutput("idle_ovf_hold", {31'b0, overflow}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp32_arith_unit.md
Name: fp32_arith_unit

Overview:
- Registered IEEE-754 single-precision arithmetic unit.
- Provides add, subtract, multiply and compare for the neuron datapath (membrane potential and recovery-variable updates, spike threshold test).
- One operation per cycle, 1-cycle latency, status flags per result.
- Internally built from an add/sub core, a multiply core and a compare core, all combinational, with a shared output register stage.

Parameters:
- CANON_NAN, 32'h7FC00000, result word driven when an exception is raised.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and op are sampled this cycle.
- op  in  2  00 add, 01 sub (a-b), 10 mul, 11 compare.
- a  in  32  operand A, IEEE-754 binary32.
- b  in  32  operand B, IEEE-754 binary32.
- out_valid  out  1  result registers hold a new result.
- result  out  32  arithmetic result; 0 for compare.
- cmp  out  2  compare code: 00 a==b, 01 a>b, 10 a<b, 11 unordered (NaN).
- exception  out  1  an operand is Inf or NaN.
- overflow  out  1  result magnitude exceeded max finite (mul and add/sub).
- underflow  out  1  nonzero result flushed to zero.

Behaviour:
- Only CLK and RESET are clocks and resets. Reset is synchronous and active-high: on a rising CLK edge with RESET=1, all outputs are cleared to 0. RESET has priority over in_valid.
- Latency is exactly 1 cycle:
  - in_valid=1 at edge N gives out_valid=1 and valid result/flags after edge N.
  - in_valid=0 gives out_valid=0; result, cmp and flags hold their last values.
- Back-to-back issue is allowed every cycle. There is no backpressure.
- Denormal inputs (exp=0) are treated as signed zero. Subnormal results are flushed to signed zero.
- Rounding is round-to-nearest-even on guard/round/sticky bits.
- Exception: if either operand has exp=0xFF (Inf or NaN), then exception=1, result=CANON_NAN, overflow=0, underflow=0. For compare, cmp=11 if either operand is NaN. Infinities compare normally, with exception still set.
- Add/sub:
  - sub inverts the sign of b.
  - Align the smaller exponent, keeping a sticky bit; add or subtract magnitudes; normalize with a leading-zero count.
  - An exact-zero result is +0, except (-0)+(-0), which gives -0.
- Mul:
  - sign = sa^sb; exponent = ea+eb-127; 24x24 mantissa product; normalize by 1 bit; round.
  - A zero operand gives signed zero.
- Overflow: if the biased exponent after rounding is 255 or more, result is sign|0x7F800000 and overflow=1.
- Underflow: if the biased exponent is 0 or less and the exact result is nonzero, result is signed zero and underflow=1.
- Compare: +0 == -0. Ordering follows sign-magnitude rules. result=0 and no overflow/underflow.
- Flags describe only the most recent accepted operation.

Optional Feature:
- FPU_STICKY_FLAGS_EN defined: adds output sticky_flags[2:0] = {exception, overflow, underflow}. Each bit is OR-accumulated on every accepted op and cleared only by RESET.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package fp32_pkg holds:
  - op codes OP_ADD, OP_SUB, OP_MUL, OP_CMP;
  - cmp codes CMP_EQ, CMP_GT, CMP_LT, CMP_UN;
  - constants EXP_BIAS=127, EXP_MAX=8'hFF, QNAN, POS_INF, NEG_INF;
  - a typedef splitting binary32 into sign, exp and frac.
- One natural sub-module: fp32_round_pack, which normalizes, rounds, detects overflow/underflow and packs the word. It is shared by the add/sub and mul paths.

Test Plan:
- RESET=1 for 2 cycles, then release: out_valid=0, result=0, cmp=0, all flags 0.
- op=00, a=0x430C0000 (140), b=0x40A00000 (5) -> next cycle result=0x43110000 (145), flags 0. Then op=01, a=0x41F00000 (30), b=0x430C0000 -> result=0xC2DC0000 (-110).
- op=10, a=0x40A00000, b=0x41F00000 -> result=0x43160000 (150). Then a=0x7F000000, b=0x40000000 -> result=0x7F800000, overflow=1.
- op=11: a=b=0x41F00000 -> cmp=00. a=0x41F00000, b=0x430C0000 -> cmp=10. a=0x80000000, b=0 -> cmp=00. a=0x7FC00000 -> cmp=11, exception=1.
- op=01, a=b=0x3D23D70A -> result=0x00000000. Then op=00, a=0x7F800000, b=0x3F800000 -> result=0x7FC00000, exception=1.
- Issue ops on consecutive cycles, assert RESET mid-stream, and drop in_valid: outputs clear on the reset edge, are valid exactly 1 cycle after each accepted op, and hold while in_valid=0.
